ifid_stage_reg: RTL and testbench

//   IF/ID pipeline stage register between instruction fetch and decode.
//   Two-entry skid buffer (main + skid) giving full throughput under back-pressure.

---
 rtl/mips_pkg.sv | 41 ++++
 rtl/ifid_stage_reg_imm_sign_decode.sv | 18 +
 rtl/ifid_stage_reg.sv | 112 +++++++++++
 tb/tb_ifid_stage_reg.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, IF/ID pipeline state and the entry format
// carried from fetch to decode.
package mips_pkg;

  localparam int IFID_ADDR_W  = 32;
  localparam int IFID_INSTR_W = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } ifid_state_t;

  typedef struct packed {
    logic [IFID_ADDR_W-1:0]  pc;
    logic [IFID_ADDR_W-1:0]  pc4;
    logic [IFID_INSTR_W-1:0] instr;
    logic                    imm_sign;
  } ifid_entry_t;

  function automatic logic [5:0] opcode_of(input logic [IFID_INSTR_W-1:0] instr);
    return instr[IFID_INSTR_W-1 -: 6];
  endfunction

endpackage

// File: rtl/ifid_stage_reg_imm_sign_decode.sv
// Opcode -> immediate extension mode. Logical immediates and LUI zero-extend;
// everything else sign-extends (R-type value is don't-care downstream).
module imm_sign_decode
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  output logic       imm_sign
);

  always_comb begin
    imm_sign = 1'b1;
    case (opcode)
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: imm_sign = 1'b0;
      default:                          imm_sign = 1'b1;
    endcase
  end

endmodule

// File: rtl/ifid_stage_reg.sv
// IF/ID stage register: two-entry skid buffer (main + skid) with flush and a
// decode-stall cycle counter. All outputs come straight from registers.
module ifid_stage_reg
  import mips_pkg::*;
#(
  parameter int ADDR_W  = IFID_ADDR_W,
  parameter int INSTR_W = IFID_INSTR_W,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               f_valid,
  output logic               f_ready,
  input  logic [ADDR_W-1:0]  f_pc,
  input  logic [INSTR_W-1:0] f_instr,
  input  logic               flush,
  output logic               d_valid,
  input  logic               d_ready,
  output logic [ADDR_W-1:0]  d_pc,
  output logic [ADDR_W-1:0]  d_pc4,
  output logic [INSTR_W-1:0] d_instr,
  output logic [15:0]        d_imm16,
  output logic               d_imm_sign,
  output logic [CNT_W-1:0]   stall_cnt
);

  ifid_state_t state, state_nxt;
  ifid_entry_t main_q, main_nxt;
  ifid_entry_t skid_q, skid_nxt;
  ifid_entry_t load_entry;
  logic        load_imm_sign;
  logic        push, pop;
  logic [CNT_W-1:0] stall_cnt_q;

  imm_sign_decode u_imm_sign_decode (
    .opcode   (opcode_of(f_instr)),
    .imm_sign (load_imm_sign)
  );

  // PC+4 and extension mode are resolved at load time so decode sees registers only.
  always_comb begin
    load_entry          = '0;
    load_entry.pc       = f_pc;
    load_entry.pc4      = f_pc + ADDR_W'(4);
    load_entry.instr    = f_instr;
    load_entry.imm_sign = load_imm_sign;
  end

  assign f_ready = (state != TWO);
  assign d_valid = (state != EMPTY);
  assign push    = f_valid & f_ready;
  assign pop     = d_valid & d_ready;

  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            state_nxt = ONE;
            main_nxt  = load_entry;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_nxt = load_entry;
          end else if (push) begin
            state_nxt = TWO;
            skid_nxt  = load_entry;
          end else if (pop) begin
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            state_nxt = ONE;
            main_nxt  = skid_q;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Stage boundary: fetch side -> decode side registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state  <= state_nxt;
      main_q <= main_nxt;
      skid_q <= skid_nxt;
      if (d_valid && !d_ready && !flush)
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign d_pc       = main_q.pc;
  assign d_pc4      = main_q.pc4;
  assign d_instr    = main_q.instr;
  assign d_imm16    = main_q.instr[15:0];
  assign d_imm_sign = main_q.imm_sign;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_ifid_stage_reg.sv
// Self-checking bench for ifid_stage_reg: directed scenarios followed by random
// traffic, all compared against a queue-based FIFO reference model.
module tb_ifid_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_valid;
  logic        f_ready;
  logic [31:0] f_pc;
  logic [31:0] f_instr;
  logic        flush;
  logic        d_valid;
  logic        d_ready;
  logic [31:0] d_pc;
  logic [31:0] d_pc4;
  logic [31:0] d_instr;
  logic [15:0] d_imm16;
  logic        d_imm_sign;
  logic [3:0]  stall_cnt;

  ifid_stage_reg #(.ADDR_W(32), .INSTR_W(32), .CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .f_valid    (f_valid),
    .f_ready    (f_ready),
    .f_pc       (f_pc),
    .f_instr    (f_instr),
    .flush      (flush),
    .d_valid    (d_valid),
    .d_ready    (d_ready),
    .d_pc       (d_pc),
    .d_pc4      (d_pc4),
    .d_instr    (d_instr),
    .d_imm16    (d_imm16),
    .d_imm_sign (d_imm_sign),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } mentry_t;

  mentry_t     q[$];
  logic [3:0]  m_cnt;
  int          n_total = 0;
  int          n_pass  = 0;
  int          n_fail  = 0;

  function automatic logic exp_sign(input logic [31:0] instr);
    int op;
    op = int'(instr[31:26]);
    return !(op >= 12 && op <= 15);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic fv, input logic [31:0] pc, input logic [31:0] instr,
                      input logic fl, input logic dr, input logic rn);
    logic    do_push, do_pop, do_stall;
    mentry_t e;
    f_valid = fv;
    f_pc    = pc;
    f_instr = instr;
    flush   = fl;
    d_ready = dr;
    rst_n   = rn;
    do_push  = fv && (q.size() < 2);
    do_pop   = (q.size() > 0) && dr;
    do_stall = (q.size() > 0) && !dr;
    e.pc     = pc;
    e.instr  = instr;
    @(posedge clk);
    if (!rn) begin
      q.delete();
      m_cnt = 4'd0;
    end else if (fl) begin
      q.delete();
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(e);
      if (do_stall) m_cnt = m_cnt + 4'd1;
    end
    #1;
    check("d_valid", d_valid, q.size() > 0);
    check("f_ready", f_ready, q.size() < 2);
    check("stall_cnt", stall_cnt, m_cnt);
    if (!rn) begin
      check("rst_d_pc", d_pc, 32'h0);
      check("rst_d_pc4", d_pc4, 32'h0);
      check("rst_d_instr", d_instr, 32'h0);
      check("rst_d_imm16", d_imm16, 32'h0);
      check("rst_d_imm_sign", d_imm_sign, 32'h0);
    end else if (q.size() > 0) begin
      check("d_pc", d_pc, q[0].pc);
      check("d_pc4", d_pc4, q[0].pc + 32'd4);
      check("d_instr", d_instr, q[0].instr);
      check("d_imm16", d_imm16, {16'h0, q[0].instr[15:0]});
      check("d_imm_sign", d_imm_sign, exp_sign(q[0].instr));
    end
  endtask

  initial begin
    logic [31:0] rpc, rinstr;
    logic [5:0]  ops [8];
    ops[0] = 6'h00; ops[1] = 6'h08; ops[2] = 6'h0C; ops[3] = 6'h0D;
    ops[4] = 6'h0E; ops[5] = 6'h0F; ops[6] = 6'h23; ops[7] = 6'h04;
    m_cnt = 4'd0;

    // reset held two cycles while fetch offers an entry
    step(1'b1, 32'h00001000, 32'h2021_0001, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h00001004, 32'h2021_0002, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);

    // streaming at full rate
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'h00400000 + 32'(4 * i), 32'h0000_0020 + 32'(i), 1'b0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);

    // back-pressure: fill both entries, hold, then drain in order
    step(1'b1, 32'h00500000, 32'h2008_00AA, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h00500004, 32'h2009_00BB, 1'b0, 1'b0, 1'b1);
    check("bp_full_f_ready", f_ready, 32'h0);
    check("bp_head_pc", d_pc, 32'h00500000);
    step(1'b1, 32'h00500008, 32'h200A_00CC, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h00500008, 32'h200A_00CC, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
    check("bp_second_pc", d_pc, 32'h00500004);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);

    // flush while full with an entry being offered
    step(1'b1, 32'h00600000, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h00600004, 32'h0000_0002, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h00600008, 32'h0000_0003, 1'b1, 1'b0, 1'b1);
    check("flush_d_valid", d_valid, 32'h0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);

    // immediate extension mode and PC+4 wrap
    step(1'b1, 32'h00700000, 32'h3421_FFFF, 1'b0, 1'b1, 1'b1);
    check("ori_imm_sign", d_imm_sign, 32'h0);
    check("ori_imm16", d_imm16, 32'h0000_FFFF);
    step(1'b1, 32'h00700004, 32'h2021_FFFF, 1'b0, 1'b1, 1'b1);
    check("addi_imm_sign", d_imm_sign, 32'h1);
    step(1'b1, 32'hFFFF_FFFC, 32'h3C01_1234, 1'b0, 1'b1, 1'b1);
    check("pc4_wrap", d_pc4, 32'h0);

    // long stall drives the 4-bit counter through 15 -> 0
    for (int i = 0; i < 20; i++)
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      rpc    = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      rinstr = $urandom;
      if ($urandom_range(0, 1) == 0) rinstr[31:26] = ops[$urandom_range(0, 7)];
      step(1'($urandom_range(0, 3) != 0), rpc, rinstr,
           1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 49) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
